// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver.
//
// Contents:
//   SEG_BLANK, SEG_DASH  segment patterns, {g,f,e,d,c,b,a} with bit0 = a
//   conv_state_t         state encoding of the sequential BCD converter
//   hex_to_seg()         4-bit digit -> segment pattern (0-9, A b C d E F)
//   clog2()              counter width helper, never returns less than 1
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    typedef enum logic [0:0] {
        CONV_IDLE = 1'b0,
        CONV_RUN  = 1'b1
    } conv_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Width of a counter that must hold 0..n-1; a 1-bit minimum keeps
    // single-state counters legal.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter.
//
// A start pulse in CONV_IDLE captures bin. Each following clock performs one
// add-3/shift step; after WIDTH steps done pulses for one cycle and bcd/lost
// carry the finished result in that same cycle, so the consumer can load it
// on the edge that ends the conversion.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts a conversion)
//   start      begin a conversion (ignored while busy)
//   bin        binary value, sampled with start
//   busy       conversion in progress
//   done       1-cycle pulse, bcd/lost valid in this cycle
//   bcd        NDIG packed BCD digits, digit 0 in bits [3:0]
//   lost       a set bit was shifted out of the top BCD digit
//
// state     | meaning
// ----------+--------------------------------------------------------
// CONV_IDLE | waiting for start, busy = 0
// CONV_RUN  | one shift/add-3 step per cycle, step counter counts down
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NDIG  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  bin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] bcd,
    output logic              lost
);

    localparam int SW = clog2(WIDTH);
    localparam int BW = 4 * NDIG;

    conv_state_t      state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]    bcd_q, bcd_d;
    logic             lost_q, lost_d;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    step_bcd;
    logic             step_lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CONV_IDLE;
            step_q  <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            lost_q  <= lost_d;
        end
    end

    // One double-dabble step on the current register contents.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        step_bcd  = {adj[BW-2:0], sh_q[WIDTH-1]};
        step_lost = lost_q | adj[BW-1];
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        lost_d  = lost_q;
        done    = 1'b0;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    state_d = CONV_RUN;
                    step_d  = SW'(WIDTH - 1);
                    sh_d    = bin;
                    bcd_d   = '0;
                    lost_d  = 1'b0;
                end
            end
            CONV_RUN: begin
                sh_d   = sh_q << 1;
                bcd_d  = step_bcd;
                lost_d = step_lost;
                if (step_q == '0) begin
                    state_d = CONV_IDLE;
                    done    = 1'b1;
                end else begin
                    step_d = step_q - SW'(1);
                end
            end
            default: begin
                state_d = CONV_IDLE;
            end
        endcase
    end

    assign busy = (state_q == CONV_RUN);
    assign bcd  = step_bcd;
    assign lost = step_lost;

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment driver with hex/decimal display of a binary value.
//
// A value accepted over value_valid/value_ready goes into a pending register
// (immediately for hex, after the sequential BCD conversion for decimal). The
// pending register is copied to the display register only when the scan wraps
// back to digit 0, so a frame never shows a mix of two values.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   value, value_valid   binary value offered for display
//   value_ready          converter idle; value taken when valid & ready
//   hex_mode, blank_lz   display mode flags, sampled with value
//   seven_segment_out    {g,f,e,d,c,b,a} of the active digit
//   seven_segment_digit  one-hot digit select, bit0 = least significant
//   sync                 1-cycle pulse with the start of each frame
//   overflow             displayed value did not fit in DIGITS digits
//   io_oeb               pad output enables, all driven (0)
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 4,
    parameter bit SEG_INV  = 1'b0,
    parameter bit DIG_INV  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic [6:0]            seven_segment_out,
    output logic [DIGITS-1:0]     seven_segment_digit,
    output logic                  sync,
    output logic                  overflow,
    output logic [8+DIGITS-1:0]   io_oeb
);

    localparam int DW    = 4 * DIGITS;
    localparam int NDIG  = DIGITS + 1;
    localparam int CW    = clog2(SCAN_DIV);
    localparam int IW    = clog2(DIGITS);
    localparam int EXT_W = (WIDTH > DW) ? WIDTH : DW;

    logic              accept;
    logic              hex_accept;
    logic              dec_accept;
    logic [EXT_W-1:0]  val_ext;
    logic              hex_ovf;

    logic              conv_busy;
    logic              conv_done;
    logic              conv_lost;
    logic [4*NDIG-1:0] conv_bcd;
    logic              dec_lz;

    // Pending register: last completed update, not yet on the display.
    logic [DW-1:0]     pend_dig;
    logic              pend_blank;
    logic              pend_lz;
    logic              pend_ovf;

    // Display register: contents of the frame currently being scanned.
    logic [DW-1:0]     disp_dig;
    logic              disp_blank;
    logic              disp_lz;
    logic              disp_ovf;

    logic [CW-1:0]     scan_cnt, nxt_cnt;
    logic [IW-1:0]     dig_idx, nxt_idx;
    logic              wrap;

    logic [DW-1:0]     nxt_dig;
    logic              nxt_blank;
    logic              nxt_lz;
    logic              nxt_ovf;
    logic [3:0]        nib;
    logic              upper_zero;
    logic [6:0]        seg_nxt;
    logic [DIGITS-1:0] dig_nxt;

    logic [6:0]        seg_q;
    logic [DIGITS-1:0] dig_q;
    logic              sync_q;
    logic              ovf_q;

    assign value_ready = ~conv_busy;
    assign accept      = value_valid & value_ready;
    assign hex_accept  = accept & hex_mode;
    assign dec_accept  = accept & ~hex_mode;

    assign val_ext = EXT_W'(value);
    assign hex_ovf = |(val_ext >> DW);

    bin2bcd_seq #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (dec_accept),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .lost  (conv_lost)
    );

    // Scan position after this edge; the output registers are loaded with
    // what belongs to that position so digit, segments and sync line up.
    always_comb begin
        wrap    = 1'b0;
        nxt_cnt = scan_cnt + CW'(1);
        nxt_idx = dig_idx;
        if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            nxt_cnt = '0;
            if (dig_idx == IW'(DIGITS - 1)) begin
                nxt_idx = '0;
                wrap    = 1'b1;
            end else begin
                nxt_idx = dig_idx + IW'(1);
            end
        end
    end

    always_comb begin
        nxt_dig   = disp_dig;
        nxt_blank = disp_blank;
        nxt_lz    = disp_lz;
        nxt_ovf   = disp_ovf;
        if (wrap) begin
            nxt_dig   = pend_dig;
            nxt_blank = pend_blank;
            nxt_lz    = pend_lz;
            nxt_ovf   = pend_ovf;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 is exempt so zero still shows a single "0".
    always_comb begin
        nib        = nxt_dig[{nxt_idx, 2'b00} +: 4];
        upper_zero = ((nxt_dig >> {nxt_idx, 2'b00}) == '0);
        dig_nxt    = DIGITS'(1) << nxt_idx;
        if (nxt_blank) begin
            seg_nxt = SEG_BLANK;
        end else if (nxt_ovf) begin
            seg_nxt = SEG_DASH;
        end else if (nxt_lz && (nxt_idx != '0) && upper_zero) begin
            seg_nxt = SEG_BLANK;
        end else begin
            seg_nxt = hex_to_seg(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_lz     <= 1'b0;
            pend_dig   <= '0;
            pend_blank <= 1'b1;
            pend_lz    <= 1'b0;
            pend_ovf   <= 1'b0;
            disp_dig   <= '0;
            disp_blank <= 1'b1;
            disp_lz    <= 1'b0;
            disp_ovf   <= 1'b0;
            scan_cnt   <= '0;
            dig_idx    <= '0;
            seg_q      <= {7{SEG_INV}};
            dig_q      <= {DIGITS{DIG_INV}};
            sync_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (hex_accept) begin
                pend_dig   <= val_ext[DW-1:0];
                pend_blank <= 1'b0;
                pend_lz    <= blank_lz;
                pend_ovf   <= hex_ovf;
            end else if (conv_done) begin
                pend_dig   <= conv_bcd[DW-1:0];
                pend_blank <= 1'b0;
                pend_lz    <= dec_lz;
                pend_ovf   <= (conv_bcd[4*NDIG-1 -: 4] != 4'd0) | conv_lost;
            end
            if (dec_accept) begin
                dec_lz <= blank_lz;
            end

            disp_dig   <= nxt_dig;
            disp_blank <= nxt_blank;
            disp_lz    <= nxt_lz;
            disp_ovf   <= nxt_ovf;
            scan_cnt   <= nxt_cnt;
            dig_idx    <= nxt_idx;

            seg_q      <= seg_nxt ^ {7{SEG_INV}};
            dig_q      <= dig_nxt ^ {DIGITS{DIG_INV}};
            sync_q     <= wrap;
            ovf_q      <= nxt_ovf & ~nxt_blank;
        end
    end

    assign seven_segment_out   = seg_q;
    assign seven_segment_digit = dig_q;
    assign sync                = sync_q;
    assign overflow            = ovf_q;
    assign io_oeb              = '0;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        value_valid;
    logic        value_ready;
    logic        hex_mode;
    logic        blank_lz;
    logic [6:0]  seven_segment_out;
    logic [3:0]  seven_segment_digit;
    logic        sync;
    logic        overflow;
    logic [11:0] io_oeb;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_display #(
        .WIDTH    (16),
        .DIGITS   (4),
        .SCAN_DIV (4),
        .SEG_INV  (1'b0),
        .DIG_INV  (1'b0)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .value               (value),
        .value_valid         (value_valid),
        .value_ready         (value_ready),
        .hex_mode            (hex_mode),
        .blank_lz            (blank_lz),
        .seven_segment_out   (seven_segment_out),
        .seven_segment_digit (seven_segment_digit),
        .sync                (sync),
        .overflow            (overflow),
        .io_oeb              (io_oeb)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0]     value;
        bit              hex;
        bit              lz;
        logic [3:0][6:0] segs;   // segs[k] = digit k
        bit              ovf;
    } vec_t;

    vec_t vecs[13];

    logic [6:0] seg_tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: split into base-10/16 digits with plain arithmetic.
    function automatic logic [3:0][6:0] model_segs(input int unsigned v, input bit hx,
                                                   input bit lz, output bit ovf);
        logic [3:0][6:0] r;
        int unsigned base, pw, d[4];
        int ms;
        base = hx ? 16 : 10;
        ovf  = (v >= base * base * base * base);
        pw   = 1;
        ms   = 0;
        for (int k = 0; k < 4; k++) begin
            d[k] = (v / pw) % base;
            pw   = pw * base;
            if (d[k] != 0) ms = k;
        end
        for (int k = 0; k < 4; k++) begin
            if (ovf)                r[k] = 7'h40;
            else if (lz && k > ms)  r[k] = 7'h00;
            else                    r[k] = seg_tbl[d[k]];
        end
        return r;
    endfunction

    task automatic send(input logic [15:0] v, input bit hx, input bit lz, output int lo);
        int w;
        w = 0;
        while (!value_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!value_ready) chk("ready_wait_timeout", value_ready, 1);
        value       = v;
        hex_mode    = hx;
        blank_lz    = lz;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        lo = 0;
        while (!value_ready && lo < 100) begin
            lo++;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input logic [3:0][6:0] exp, input bit exp_ovf);
        int w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!sync && w < 64);
        chk({tag, "_sync"}, sync, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            chk($sformatf("%s_d%0d_sel", tag, k), seven_segment_digit, 32'(4'b0001 << k));
            chk($sformatf("%s_d%0d_seg", tag, k), seven_segment_out, exp[k]);
        end
        chk({tag, "_ovf"}, overflow, exp_ovf);
    endtask

    initial begin
        int lo, w, cnt;
        bit prev_ovf, m_ovf;
        logic [3:0][6:0] m_segs;
        logic [15:0] rv;
        bit rh, rl;

        seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        vecs[0]  = '{16'd1234,  1'b0, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0};
        vecs[1]  = '{16'hBEEF,  1'b1, 1'b0, {7'h7C, 7'h79, 7'h79, 7'h71}, 1'b0};
        vecs[2]  = '{16'd12345, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
        vecs[3]  = '{16'd42,    1'b0, 1'b0, {7'h3F, 7'h3F, 7'h66, 7'h5B}, 1'b0};
        vecs[4]  = '{16'd7,     1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h07}, 1'b0};
        vecs[5]  = '{16'd0,     1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0};
        vecs[6]  = '{16'h00A0,  1'b1, 1'b1, {7'h00, 7'h00, 7'h77, 7'h3F}, 1'b0};
        vecs[7]  = '{16'd9999,  1'b0, 1'b0, {7'h6F, 7'h6F, 7'h6F, 7'h6F}, 1'b0};
        vecs[8]  = '{16'd10000, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
        vecs[9]  = '{16'h0005,  1'b1, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h6D}, 1'b0};
        vecs[10] = '{16'd65535, 1'b0, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
        vecs[11] = '{16'd305,   1'b0, 1'b1, {7'h00, 7'h4F, 7'h3F, 7'h6D}, 1'b0};
        vecs[12] = '{16'h1000,  1'b1, 1'b1, {7'h06, 7'h3F, 7'h3F, 7'h3F}, 1'b0};

        rst         = 1'b1;
        value       = '0;
        value_valid = 1'b0;
        hex_mode    = 1'b0;
        blank_lz    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_seg",   seven_segment_out,   0);
        chk("rst_digit", seven_segment_digit, 0);
        chk("rst_sync",  sync,                0);
        chk("rst_ovf",   overflow,            0);
        chk("rst_ready", value_ready,         1);
        chk("rst_oeb",   io_oeb,              0);

        rst = 1'b0;
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (sync) break;
        end
        chk("first_sync_cycles", cnt, 16);
        chk("first_frame_blank", seven_segment_out, 0);
        chk("first_frame_dig0",  seven_segment_digit, 4'b0001);

        prev_ovf = 1'b0;
        foreach (vecs[i]) begin
            send(vecs[i].value, vecs[i].hex, vecs[i].lz, lo);
            chk($sformatf("vec%0d_ready_low", i), lo, vecs[i].hex ? 0 : 16);
            chk($sformatf("vec%0d_ovf_hold", i), overflow, prev_ovf);
            check_frame($sformatf("vec%0d", i), vecs[i].segs, vecs[i].ovf);
            prev_ovf = vecs[i].ovf;
        end

        for (int i = 0; i < 16; i++) begin
            rv = (i % 2 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 300));
            rh = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            m_segs = model_segs(rv, rh, rl, m_ovf);
            send(rv, rh, rl, lo);
            chk($sformatf("rnd%0d_ready_low", i), lo, rh ? 0 : 16);
            chk($sformatf("rnd%0d_ovf_hold", i), overflow, prev_ovf);
            check_frame($sformatf("rnd%0d", i), m_segs, m_ovf);
            prev_ovf = m_ovf;
        end

        // Valid pulse during a conversion is dropped.
        value = 16'd1234; hex_mode = 1'b0; blank_lz = 1'b0; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        lo = 0;
        for (int i = 0; i < 100; i++) begin
            if (value_ready) break;
            lo++;
            if (i == 3) begin
                value = 16'hFFFF; hex_mode = 1'b1; value_valid = 1'b1;
            end else begin
                value_valid = 1'b0;
            end
            @(negedge clk);
        end
        value_valid = 1'b0;
        chk("busy_ignore_ready_low", lo, 16);
        check_frame("busy_ignore", {7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b0);

        // Mid-frame updates wait for the frame boundary; last one wins.
        send(16'h1111, 1'b1, 1'b0, lo);
        check_frame("pre_mid", {7'h06, 7'h06, 7'h06, 7'h06}, 1'b0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!sync && w < 64);
        repeat (5) @(negedge clk);
        value = 16'h2222; hex_mode = 1'b1; blank_lz = 1'b0; value_valid = 1'b1;
        @(negedge clk);
        value = 16'h3333;
        @(negedge clk);
        value_valid = 1'b0;
        w = 0;
        while (seven_segment_digit != 4'b1000 && w < 32) begin
            @(negedge clk);
            w++;
        end
        chk("mid_frame_old_sel", seven_segment_digit, 4'b1000);
        chk("mid_frame_old_seg", seven_segment_out, 7'h06);
        check_frame("last_wins", {7'h4F, 7'h4F, 7'h4F, 7'h4F}, 1'b0);

        // Reset in the middle of a conversion.
        value = 16'd9999; hex_mode = 1'b0; blank_lz = 1'b0; value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midconv_busy", value_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midconv_rst_seg", seven_segment_out, 0);
        @(negedge clk);
        chk("midconv_ready_after", value_ready, 1);
        check_frame("midconv_blank", {7'h00, 7'h00, 7'h00, 7'h00}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
